truth_table_scanner: RTL and testbench
======================================

TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 SHALL have parameter N, default 3, meaning number of Boolean variables (legal range 1..6).
REQ-002 SHALL have derived localparam W = 2**N, meaning the number of truth-table rows.
REQ-003 SHALL have port clk, input, 1, meaning the single rising-edge clock.
REQ-004 SHALL have port rst_n, input, 1, meaning the asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, meaning a request to begin a scan; sampled only in IDLE.
REQ-006 SHALL have port hold, input, 1, meaning stall the scan for the current cycle.
REQ-007 SHALL have port func_a, input, W, meaning the reference truth table; bit i is F(minterm i).
REQ-008 SHALL have port func_b, input, W, meaning the candidate truth table (e.g. PoS form) to compare.
REQ-009 SHALL have port busy, output, 1, meaning the block is in SCAN.
REQ-010 SHALL have port row_valid, output, 1, meaning row_idx, row_a and row_b describe a scanned row this cycle.
REQ-011 SHALL have port row_idx, output, N, meaning the minterm index; bit N-1 is the MSB variable (x of xyz).
REQ-012 SHALL have port row_a and port row_b, each output, 1, meaning the F values of that row.
REQ-013 SHALL have port done, output, 1, meaning a one-cycle pulse at scan completion.
REQ-014 SHALL have ports ones_cnt and mism_cnt, each output, N+1, meaning the count of minterms (func_a=1) and the count of rows with a != b.
REQ-015 SHALL have port equal, output, 1, meaning that mism_cnt == 0 after the last scan.
REQ-016 SHALL have port first_mism, output, N, meaning the lowest row index with a != b (0 if none).

Function
REQ-017 SHALL implement the FSM states IDLE, SCAN and DONE.
REQ-018 SHALL transition IDLE->SCAN on start=1, capture func_a/func_b into internal registers, set the index to 0 and clear the counters.
REQ-019 SHALL ignore changes to func_a/func_b after capture until the next start.
REQ-020 SHALL, in SCAN with hold=0, assert row_valid for index i, present the captured bits, and update the counters in the same cycle.
REQ-021 SHALL, in SCAN with hold=1, deassert row_valid and freeze the index and counters.
REQ-022 SHALL make the scan take exactly W unheld cycles, from row 0 to row W-1 in ascending order.
REQ-023 SHALL go SCAN->DONE on the cycle after row W-1 is presented; the index SHALL not wrap.
REQ-024 SHALL pulse done=1 for exactly one cycle in DONE, then go to IDLE.
REQ-025 SHALL add one to ones_cnt per row where row_a=1, and add one to mism_cnt per row where row_a!=row_b.
REQ-026 SHALL size both counters at N+1 bits so that they never overflow; the maximum value is W.
REQ-027 SHALL latch first_mism only on the first mismatch of a scan.
REQ-028 SHALL update equal only in DONE and hold it until the next DONE.
REQ-029 SHALL hold ones_cnt, mism_cnt and first_mism stable in IDLE until the next start.
REQ-030 SHALL ignore start=1 during SCAN or DONE; it SHALL not be queued.
REQ-031 SHALL respond to start held high continuously with back-to-back scans; IDLE is one cycle between scans.
REQ-032 SHALL make row_idx, row_a and row_b don't-care when row_valid=0; they SHALL hold their last value.

Reset
REQ-033 SHALL, on rst_n=0 at any time, including mid-SCAN, immediately force: state IDLE; busy, row_valid, done, row_a, row_b = 0; row_idx, ones_cnt, mism_cnt, first_mism = 0; equal = 0.
REQ-034 SHALL, after rst_n deasserts, make no scan start until a start is sampled high at a clock edge.

Verification
REQ-035 SHALL cover: N=3, func_a=func_b=8'b0010_0010 (F = m1+m5), start pulse -> rows 0..7 in 8 cycles; row_a=1 at idx 1 and 5; done on cycle 10 after start; ones_cnt=2, mism_cnt=0, equal=1.
REQ-036 SHALL cover: N=3, func_a=8'b0010_0010, func_b=8'b0010_0011 -> mism_cnt=1, first_mism=0, equal=0.
REQ-037 SHALL cover: hold asserted for 3 cycles at row 4 -> no row_valid during the hold; the scan resumes at row 4; done is 3 cycles later than in REQ-035; counts are unchanged.
REQ-038 SHALL cover: rst_n pulsed low at row 5 -> all outputs 0 asynchronously; a new start rescans from row 0 with correct counts.
REQ-039 SHALL cover: N=6, func_a all ones, func_b all zeros -> ones_cnt=64, mism_cnt=64 (7-bit, no overflow), first_mism=0, equal=0.
REQ-040 SHALL cover: start re-pulsed mid-scan and func_a changed mid-scan -> no restart and results match the captured tables.

Source files
------------

// File: rtl/truth_table_scanner.sv
// rtl/truth_table_scanner.sv - scans two captured truth tables row by row, counting minterms and mismatches
module truth_table_scanner #(
  parameter int N = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               hold,
  input  logic [2**N-1:0]    func_a,
  input  logic [2**N-1:0]    func_b,
  output logic               busy,
  output logic               row_valid,
  output logic [N-1:0]       row_idx,
  output logic               row_a,
  output logic               row_b,
  output logic               done,
  output logic [N:0]         ones_cnt,
  output logic [N:0]         mism_cnt,
  output logic               equal,
  output logic [N-1:0]       first_mism
);

  localparam int W = 2**N;
  localparam logic [N-1:0] IDX_ONE  = 1;
  localparam logic [N-1:0] IDX_LAST = N'(W - 1);
  localparam logic [N:0]   CNT_ONE  = 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   a_q, b_q;
  logic [N-1:0]   idx;
  logic           last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (!hold && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SCAN);

  // last marks that row W-1 has been presented, so idx never has to wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      idx        <= '0;
      last       <= 1'b0;
      row_valid  <= 1'b0;
      row_idx    <= '0;
      row_a      <= 1'b0;
      row_b      <= 1'b0;
      done       <= 1'b0;
      ones_cnt   <= '0;
      mism_cnt   <= '0;
      equal      <= 1'b0;
      first_mism <= '0;
    end else begin
      row_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q        <= func_a;
            b_q        <= func_b;
            idx        <= '0;
            last       <= 1'b0;
            ones_cnt   <= '0;
            mism_cnt   <= '0;
            first_mism <= '0;
          end
        end
        SCAN: begin
          if (!hold) begin
            if (last) begin
              done  <= 1'b1;
              equal <= (mism_cnt == '0);
            end else begin
              row_valid <= 1'b1;
              row_idx   <= idx;
              row_a     <= a_q[idx];
              row_b     <= b_q[idx];
              if (a_q[idx]) ones_cnt <= ones_cnt + CNT_ONE;
              if (a_q[idx] != b_q[idx]) begin
                mism_cnt <= mism_cnt + CNT_ONE;
                if (mism_cnt == '0) first_mism <= idx;
              end
              if (idx == IDX_LAST) last <= 1'b1;
              else                 idx  <= idx + IDX_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
// tb/tb_truth_table_scanner.sv - directed self-checking bench for truth_table_scanner (N=3 and N=6)
module tb_truth_table_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        hold = 1'b0;
  logic [7:0]  func_a = '0;
  logic [7:0]  func_b = '0;
  logic        busy, row_valid, row_a, row_b, done, equal;
  logic [2:0]  row_idx, first_mism;
  logic [3:0]  ones_cnt, mism_cnt;

  logic        start6 = 1'b0;
  logic [63:0] func_a6 = '0;
  logic [63:0] func_b6 = '0;
  logic        busy6, row_valid6, row_a6, row_b6, done6, equal6;
  logic [5:0]  row_idx6, first_mism6;
  logic [6:0]  ones_cnt6, mism_cnt6;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;

  always #5 clk = ~clk;

  truth_table_scanner #(.N(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
    .func_a(func_a), .func_b(func_b), .busy(busy), .row_valid(row_valid),
    .row_idx(row_idx), .row_a(row_a), .row_b(row_b), .done(done),
    .ones_cnt(ones_cnt), .mism_cnt(mism_cnt), .equal(equal), .first_mism(first_mism)
  );

  truth_table_scanner #(.N(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .start(start6), .hold(1'b0),
    .func_a(func_a6), .func_b(func_b6), .busy(busy6), .row_valid(row_valid6),
    .row_idx(row_idx6), .row_a(row_a6), .row_b(row_b6), .done(done6),
    .ones_cnt(ones_cnt6), .mism_cnt(mism_cnt6), .equal(equal6), .first_mism(first_mism6)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one N=3 scan; optionally holds before row hold_at, or re-pulses start and
  // corrupts the inputs just before row poke_at. Returns edges from start to done.
  task automatic scan(input logic [7:0] a, input logic [7:0] b, input int hold_at,
                      input int hold_len, input int poke_at, output int cycles);
    int  exp_row;
    int  held;
    logic hnow;
    exp_row = 0;
    held    = 0;
    func_a  = a;
    func_b  = b;
    start   = 1'b1;
    tick();
    start  = 1'b0;
    cycles = 1;
    while (exp_row < 8 && cycles < 40) begin
      hnow = (exp_row == hold_at) && (held < hold_len);
      hold = hnow;
      if (exp_row == poke_at) begin
        start  = 1'b1;
        func_a = ~a;
        func_b = ~b;
      end
      tick();
      cycles++;
      start = 1'b0;
      if (hnow) begin
        held++;
        chk("hold_row_valid", row_valid, 0);
      end else begin
        chk("row_valid", row_valid, 1);
        chk("row_idx", row_idx, exp_row);
        chk("row_a", row_a, a[exp_row]);
        chk("row_b", row_b, b[exp_row]);
        chk("busy", busy, 1);
        exp_row++;
      end
    end
    hold = 1'b0;
    tick();
    cycles++;
    chk("done_pulse", done, 1);
  endtask

  task automatic results(input string tag, input int exp_cyc, input int cycles, input int ones,
                         input int mism, input int first, input int eq);
    chk({tag, "_cycles"}, cycles, exp_cyc);
    chk({tag, "_ones"}, ones_cnt, ones);
    chk({tag, "_mism"}, mism_cnt, mism);
    chk({tag, "_first"}, first_mism, first);
    chk({tag, "_equal"}, equal, eq);
    tick();
    chk({tag, "_done_off"}, done, 0);
    chk({tag, "_busy_off"}, busy, 0);
    tick();
    chk({tag, "_idle_ones"}, ones_cnt, ones);
    chk({tag, "_idle_mism"}, mism_cnt, mism);
  endtask

  initial begin
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_row_valid", row_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_ones", ones_cnt, 0);
    chk("rst_equal", equal, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) tick();
    chk("no_start_busy", busy, 0);

    scan(8'b0010_0010, 8'b0010_0010, 99, 0, 99, cyc);
    results("m1m5", 10, cyc, 2, 0, 0, 1);

    scan(8'b0010_0010, 8'b0010_0011, 99, 0, 99, cyc);
    results("b_m0", 10, cyc, 2, 1, 0, 0);

    scan(8'b0010_0010, 8'b0010_0010, 4, 3, 99, cyc);
    results("hold", 13, cyc, 2, 0, 0, 1);

    scan(8'hFF, 8'h0F, 99, 0, 99, cyc);
    results("upper", 10, cyc, 8, 4, 4, 0);

    scan(8'b1001_0110, 8'b1001_0110, 99, 0, 3, cyc);
    results("poke", 10, cyc, 4, 0, 0, 1);

    scan(8'h00, 8'h00, 99, 0, 99, cyc);
    results("zero", 10, cyc, 0, 0, 0, 1);

    func_a = 8'b0010_0010;
    func_b = 8'b0010_0010;
    start  = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("pre_rst_idx", row_idx, 5);
    chk("pre_rst_row_a", row_a, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_row_valid", row_valid, 0);
    chk("arst_row_idx", row_idx, 0);
    chk("arst_row_a", row_a, 0);
    chk("arst_done", done, 0);
    chk("arst_ones", ones_cnt, 0);
    chk("arst_mism", mism_cnt, 0);
    chk("arst_first", first_mism, 0);
    chk("arst_equal", equal, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_row_valid", row_valid, 0);

    scan(8'b0010_0010, 8'b0010_0011, 99, 0, 99, cyc);
    results("rescan", 10, cyc, 2, 1, 0, 0);

    func_a6 = {64{1'b1}};
    func_b6 = '0;
    start6  = 1'b1;
    tick();
    start6 = 1'b0;
    cyc = 1;
    while (!done6 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("n6_done", done6, 1);
    chk("n6_cycles", cyc, 66);
    chk("n6_ones", ones_cnt6, 64);
    chk("n6_mism", mism_cnt6, 64);
    chk("n6_first", first_mism6, 0);
    chk("n6_equal", equal6, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
